// File: rtl/as5600_i2c_target.sv
// I2C target emulating the AS5600 angle/status register read interface.
// Latency: 3 clk_50m from a pin edge to internal event; sda_oe moves 3-4 clk after SCL falls.
// Backpressure: none, the bus initiator owns SCL and the target never stretches the clock.
module as5600_i2c_target #(
  parameter logic [6:0] SLAVE_ADDR = 7'h36,
  parameter logic [7:0] STATUS_VAL = 8'h20
) (
  input  logic        clk_50m,
  input  logic        rstn,
  input  logic        scl_i,
  input  logic        sda_i,
  output logic        sda_oe,
  input  logic [11:0] angle_i,
  output logic        busy,
  output logic        rd_byte,
  output logic [7:0]  ptr_o
);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, REG, REG_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK
  } state_t;

  state_t      state;
  logic        scl_s1, scl_s2, scl_d;
  logic        sda_s1, sda_s2, sda_d;
  logic [2:0]  cnt;
  logic [7:0]  sh;
  logic        rw;
  logic        nine;      // 9th (ACK) clock has risen in the current ACK state
  logic [11:0] angle_q;

  logic scl_rise, scl_fall, start_det, stop_det;
  logic [7:0] ptr_inc, snap_byte, next_byte;

  function automatic logic [7:0] reg_map(input logic [7:0] a, input logic [11:0] ang);
    case (a)
      8'h0B:        reg_map = STATUS_VAL;
      8'h0C, 8'h0E: reg_map = {4'h0, ang[11:8]};
      8'h0D, 8'h0F: reg_map = ang[7:0];
      default:      reg_map = 8'h00;
    endcase
  endfunction

  // Sync both bus lines (idle-high) and keep one delayed copy for edge detection
  always_ff @(posedge clk_50m or negedge rstn) begin
    if (!rstn) begin
      scl_s1 <= 1'b1; scl_s2 <= 1'b1; scl_d <= 1'b1;
      sda_s1 <= 1'b1; sda_s2 <= 1'b1; sda_d <= 1'b1;
    end else begin
      scl_s1 <= scl_i; scl_s2 <= scl_s1; scl_d <= scl_s2;
      sda_s1 <= sda_i; sda_s2 <= sda_s1; sda_d <= sda_s2;
    end
  end

  assign scl_rise  = scl_s2 & ~scl_d;
  assign scl_fall  = ~scl_s2 & scl_d;
  assign start_det = scl_s2 & scl_d & sda_d & ~sda_s2;
  assign stop_det  = scl_s2 & scl_d & ~sda_d & sda_s2;
  assign ptr_inc   = ptr_o + 8'd1;
  // First read byte uses the live angle because the snapshot is taken on the same edge
  assign snap_byte = reg_map(ptr_o, angle_i);
  assign next_byte = reg_map(ptr_inc, angle_q);

  // Protocol FSM: START/STOP override everything, otherwise bit-level handling per state
  always_ff @(posedge clk_50m or negedge rstn) begin
    if (!rstn) begin
      state   <= IDLE;
      cnt     <= 3'd0;
      sh      <= 8'h00;
      rw      <= 1'b0;
      nine    <= 1'b0;
      angle_q <= 12'h000;
      sda_oe  <= 1'b0;
      busy    <= 1'b0;
      rd_byte <= 1'b0;
      ptr_o   <= 8'h00;
    end else begin
      rd_byte <= 1'b0;
      if (start_det) begin
        state  <= ADDR;
        cnt    <= 3'd0;
        nine   <= 1'b0;
        sda_oe <= 1'b0;
        busy   <= 1'b1;
      end else if (stop_det) begin
        state  <= IDLE;
        nine   <= 1'b0;
        sda_oe <= 1'b0;
        busy   <= 1'b0;
      end else begin
        case (state)
          IDLE: ;
          ADDR, REG, WDATA: begin
            if (scl_rise) begin
              sh  <= {sh[6:0], sda_s2};
              cnt <= cnt + 3'd1;
              if (cnt == 3'd7) begin
                nine <= 1'b0;
                if (state == ADDR) begin
                  // sh[6:0] holds the 7 address bits, the bit arriving now is R/W
                  if (sh[6:0] == SLAVE_ADDR) begin
                    state <= ADDR_ACK;
                    rw    <= sda_s2;
                  end else begin
                    state <= IDLE;
                  end
                end else if (state == REG) begin
                  state <= REG_ACK;
                end else begin
                  state <= WDATA_ACK;
                end
              end
            end
          end
          ADDR_ACK, REG_ACK, WDATA_ACK: begin
            if (scl_rise) begin
              nine <= 1'b1;
            end else if (scl_fall) begin
              if (!nine) begin
                sda_oe <= 1'b1;
              end else begin
                nine <= 1'b0;
                cnt  <= 3'd0;
                if (state == ADDR_ACK && rw) begin
                  angle_q <= angle_i;
                  sh      <= snap_byte;
                  sda_oe  <= ~snap_byte[7];
                  state   <= RDATA;
                end else if (state == ADDR_ACK) begin
                  sda_oe <= 1'b0;
                  state  <= REG;
                end else if (state == REG_ACK) begin
                  sda_oe <= 1'b0;
                  ptr_o  <= sh;
                  state  <= WDATA;
                end else begin
                  sda_oe <= 1'b0;
                  ptr_o  <= ptr_inc;
                  state  <= WDATA;
                end
              end
            end
          end
          RDATA: begin
            if (scl_rise) begin
              cnt <= cnt + 3'd1;
              if (cnt == 3'd7) state <= RDATA_ACK;
            end else if (scl_fall) begin
              // cnt = bits already clocked, so this picks the next bit MSB first
              sda_oe <= ~sh[3'd7 - cnt];
            end
          end
          RDATA_ACK: begin
            if (scl_fall) begin
              sda_oe <= 1'b0;
            end else if (scl_rise) begin
              rd_byte <= 1'b1;
              ptr_o   <= ptr_inc;
              cnt     <= 3'd0;
              if (!sda_s2) begin
                sh    <= next_byte;
                state <= RDATA;
              end else begin
                state <= IDLE;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
